// File: rtl/jsv_led_sequencer_if.sv
// Avalon-MM slave bus bundle for the LED sequencer: register select,
// write strobe/data and zero-wait-state read data.
interface jsv_led_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/jsv_led_sequencer.sv
// LED pattern sequencer: software appends patterns into a small buffer and the
// block steps through them at a programmable rate, once or looping, raising a
// level interrupt on loop wrap-around.
module jsv_led_sequencer #(
  parameter int WIDTH    = 14,
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  jsv_led_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 irq
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Register state
  state_t              state_r;
  logic                run_r;
  logic                loop_r;
  logic                irq_en_r;
  logic [PERIOD_W-1:0] period_r;
  logic [4:0]          count_r;
  logic [4:0]          idx_r;
  logic [PERIOD_W-1:0] timer_r;
  logic                overflow_r;
  logic                wrapped_r;
  logic [WIDTH-1:0]    out_r;
  logic                irq_r;
  logic [WIDTH-1:0]    pat_mem [DEPTH];

  // Decoded bus strobes and FSM next-state values
  logic                wr_s;
  logic                wr_ctrl_s;
  logic                wr_period_s;
  logic                wr_pat_s;
  logic                wr_status_s;
  logic                clear_s;
  logic                append_ok_s;
  logic                append_drop_s;
  logic [PERIOD_W-1:0] reload_s;
  logic [4:0]          idx_inc_s;
  logic                last_s;
  state_t              state_nxt_s;
  logic [WIDTH-1:0]    out_nxt_s;
  logic [4:0]          idx_nxt_s;
  logic [PERIOD_W-1:0] timer_nxt_s;
  logic                wrap_set_s;

  assign wr_s          = bus.chipselect & ~bus.write_n;
  assign wr_ctrl_s     = wr_s & (bus.address == 2'd0);
  assign wr_period_s   = wr_s & (bus.address == 2'd1);
  assign wr_pat_s      = wr_s & (bus.address == 2'd2);
  assign wr_status_s   = wr_s & (bus.address == 2'd3);
  assign clear_s       = wr_ctrl_s & bus.writedata[2];
  assign append_ok_s   = wr_pat_s & (count_r < DEPTH_C);
  assign append_drop_s = wr_pat_s & (count_r == DEPTH_C);

  // A programmed period of zero behaves like one cycle per step.
  assign reload_s  = (period_r == {PERIOD_W{1'b0}}) ? PERIOD_W'(1'b1) : period_r;
  assign idx_inc_s = idx_r + 5'd1;
  assign last_s    = (idx_inc_s >= count_r);

  assign out_port = out_r;
  assign irq      = irq_r;

  // Zero-wait-state register readback selected purely by address.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata = {28'd0, irq_en_r, 1'b0, loop_r, run_r};
      2'd1:    bus.readdata = 32'(period_r);
      2'd2:    bus.readdata = 32'(out_r);
      2'd3:    bus.readdata = {21'd0, (state_r != IDLE), wrapped_r, overflow_r, 3'd0, count_r};
      default: bus.readdata = 32'd0;
    endcase
  end

  // Sequencer next-state: start, step, wrap, finish and stop decisions.
  always_comb begin
    state_nxt_s = state_r;
    out_nxt_s   = out_r;
    idx_nxt_s   = idx_r;
    timer_nxt_s = timer_r;
    wrap_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_r && (count_r != 5'd0)) begin
          state_nxt_s = PLAY;
          idx_nxt_s   = 5'd0;
          out_nxt_s   = pat_mem[{IDX_W{1'b0}}];
          timer_nxt_s = reload_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PLAY: begin
        if (!run_r) begin
          state_nxt_s = IDLE;
        end else if (timer_r == PERIOD_W'(1'b1)) begin
          if (!last_s) begin
            idx_nxt_s   = idx_inc_s;
            out_nxt_s   = pat_mem[idx_inc_s[IDX_W-1:0]];
            timer_nxt_s = reload_s;
          end else if (loop_r) begin
            idx_nxt_s   = 5'd0;
            out_nxt_s   = pat_mem[{IDX_W{1'b0}}];
            timer_nxt_s = reload_s;
            wrap_set_s  = 1'b1;
          end else begin
            state_nxt_s = HOLD;
          end
        end else begin
          timer_nxt_s = timer_r - PERIOD_W'(1'b1);
        end
      end
      HOLD: begin
        if (!run_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state register; a clear command overrides the FSM step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      out_r   <= {WIDTH{1'b0}};
      idx_r   <= 5'd0;
      timer_r <= {PERIOD_W{1'b0}};
    end else if (clear_s) begin
      state_r <= IDLE;
      out_r   <= {WIDTH{1'b0}};
      idx_r   <= 5'd0;
      timer_r <= {PERIOD_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
      idx_r   <= idx_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // CONTROL and PERIOD registers; the clear bit is a strobe, never stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r    <= 1'b0;
      loop_r   <= 1'b0;
      irq_en_r <= 1'b0;
      period_r <= PERIOD_W'(1'b1);
    end else begin
      if (wr_ctrl_s) begin
        run_r    <= bus.writedata[0];
        loop_r   <= bus.writedata[1];
        irq_en_r <= bus.writedata[3];
      end
      if (wr_period_s) begin
        period_r <= bus.writedata[PERIOD_W-1:0];
      end
    end
  end

  // Buffer fill level: appends grow it, clear empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 5'd0;
    end else if (clear_s) begin
      count_r <= 5'd0;
    end else if (append_ok_s) begin
      count_r <= count_r + 5'd1;
    end
  end

  // Pattern storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (append_ok_s) begin
      pat_mem[count_r[IDX_W-1:0]] <= bus.writedata[WIDTH-1:0];
    end
  end

  // Sticky status flags: hardware set has priority over write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
      wrapped_r  <= 1'b0;
    end else begin
      if (append_drop_s) begin
        overflow_r <= 1'b1;
      end else if (wr_status_s && bus.writedata[8]) begin
        overflow_r <= 1'b0;
      end
      if (wrap_set_s && !clear_s) begin
        wrapped_r <= 1'b1;
      end else if (wr_status_s && bus.writedata[9]) begin
        wrapped_r <= 1'b0;
      end
    end
  end

  // Registered level interrupt from the wrap flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= wrapped_r & irq_en_r;
    end
  end

endmodule
